tile_stage_loader: RTL and testbench

- Upstream feeder for the transpose FIFO in the systolic matmul datapath.
- Accepts a valid/ready stream of BITS-wide row words and assembles DEPTH words into a tile.
- Issues a one-cycle parallel load (p_load + wr_en) to the transpose FIFO, then drives its shift enable for exactly DEPTH accepted cycles.
- Double-buffered (ping-pong), so the next tile fills while the current one drains.

---
 rtl/tile_stage_loader_pkg.sv | 21 ++
 rtl/tile_stage_loader_if.sv | 35 +++
 rtl/tile_stage_loader_bank.sv | 35 +++
 rtl/tile_stage_loader.sv | 157 +++++++++++++++
 tb/tb_tile_stage_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_stage_loader_pkg.sv
// Shared definitions for the tile stage loader slice: drain FSM state
// encoding, default geometry, and the counter-width helper used to size the
// fill and shift counters.
package tile_stage_loader_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int BITS_DEF  = 64;
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } loader_state_t;

  // Counter width for a tile of the given depth (never narrower than 1 bit).
  function automatic int cnt_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tile_stage_loader_if.sv
// Stream and transpose-FIFO bundle for tile_stage_loader.
//   in_valid/in_data/in_ready : upstream row-word stream
//   drain_ready               : consumer permits a shift this cycle
//   p_load/wr_en              : parallel tile load into the FIFO
//   shift_en/fifo_d           : FIFO shift enable and serial input (zero)
//   q_valid/tile_done/busy    : status
// master = stream source / FIFO side, slave = the loader.
interface tile_stage_loader_if
  import tile_stage_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int BITS  = BITS_DEF
);
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            drain_ready;
  logic [BITS-1:0] p_load [DEPTH-1:0];
  logic            wr_en;
  logic            shift_en;
  logic [BITS-1:0] fifo_d;
  logic            q_valid;
  logic            tile_done;
  logic            busy;

  modport master (
    output in_valid, in_data, drain_ready,
    input  in_ready, p_load, wr_en, shift_en, fifo_d, q_valid, tile_done, busy
  );

  modport slave (
    input  in_valid, in_data, drain_ready,
    output in_ready, p_load, wr_en, shift_en, fifo_d, q_valid, tile_done, busy
  );
endinterface

// File: rtl/tile_stage_loader_bank.sv
// One tile buffer: DEPTH x BITS register file with single indexed write,
// whole-tile combinational read and synchronous clear.
//   clk, rst_n : clock, async active-low reset (contents zeroed)
//   clr        : sync clear of all words
//   we/waddr/wdata : word write
//   rdata      : full tile contents
module tile_stage_bank
  import tile_stage_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  logic [BITS-1:0]  wdata,
  output logic [BITS-1:0]  rdata [DEPTH-1:0]
);
  logic [BITS-1:0] mem [DEPTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem;
endmodule

// File: rtl/tile_stage_loader.sv
// Ping-pong tile assembler feeding the transpose FIFO. Row words are
// collected into one of two banks; a full bank is handed to the FIFO with a
// one-cycle parallel load, then the FIFO is shifted once per drain_ready
// cycle for DEPTH shifts while the other bank fills.
//   clk   : clock
//   rst_n : async active-low reset
//   flush : sync clear of all state (priority over everything else)
//   bus   : stream / FIFO bundle (slave side)
module tile_stage_loader
  import tile_stage_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int BITS  = BITS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  tile_stage_loader_if.slave bus
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  loader_state_t    state;
  logic             fill_bank;
  logic             drain_bank;
  logic [1:0]       bank_full;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] shift_cnt;
  logic             wr_en_r;
  logic             q_valid_r;
  logic             tile_done_r;

  logic             accept;
  logic             load_clr;
  logic [BITS-1:0]  rd0 [DEPTH-1:0];
  logic [BITS-1:0]  rd1 [DEPTH-1:0];

  assign bus.in_ready  = !bank_full[fill_bank];
  assign accept        = bus.in_valid && bus.in_ready;
  assign load_clr      = (state == LOAD);

  assign bus.wr_en     = wr_en_r;
  assign bus.q_valid   = q_valid_r;
  assign bus.shift_en  = q_valid_r && bus.drain_ready;
  assign bus.tile_done = tile_done_r;
  assign bus.fifo_d    = '0;
  assign bus.busy      = (|bank_full) || (state != IDLE);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) bus.p_load[k] = drain_bank ? rd1[k] : rd0[k];
  end

  tile_stage_bank #(.DEPTH(DEPTH), .BITS(BITS), .CNT_W(CNT_W)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .we    (accept && !fill_bank),
    .waddr (fill_cnt),
    .wdata (bus.in_data),
    .rdata (rd0)
  );

  tile_stage_bank #(.DEPTH(DEPTH), .BITS(BITS), .CNT_W(CNT_W)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .we    (accept && fill_bank),
    .waddr (fill_cnt),
    .wdata (bus.in_data),
    .rdata (rd1)
  );

  // Fill side: the bank being drained is released in LOAD, so in_ready can
  // only see it free the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_bank <= 1'b0;
      fill_cnt  <= '0;
      bank_full <= '0;
    end else if (flush) begin
      fill_bank <= 1'b0;
      fill_cnt  <= '0;
      bank_full <= '0;
    end else begin
      if (accept) begin
        if (fill_cnt == LAST) begin
          fill_cnt             <= '0;
          fill_bank            <= !fill_bank;
          bank_full[fill_bank] <= 1'b1;
        end else begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
      if (load_clr) bank_full[drain_bank] <= 1'b0;
    end
  end

  // Drain FSM: wr_en and q_valid are registered alongside the state so they
  // are clean decodes of LOAD and SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      drain_bank  <= 1'b0;
      shift_cnt   <= '0;
      wr_en_r     <= 1'b0;
      q_valid_r   <= 1'b0;
      tile_done_r <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      drain_bank  <= 1'b0;
      shift_cnt   <= '0;
      wr_en_r     <= 1'b0;
      q_valid_r   <= 1'b0;
      tile_done_r <= 1'b0;
    end else begin
      tile_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bank_full[drain_bank]) begin
            state   <= LOAD;
            wr_en_r <= 1'b1;
          end
        end
        LOAD: begin
          state      <= SHIFT;
          wr_en_r    <= 1'b0;
          q_valid_r  <= 1'b1;
          drain_bank <= !drain_bank;
          shift_cnt  <= '0;
        end
        SHIFT: begin
          if (bus.drain_ready) begin
            if (shift_cnt == LAST) begin
              shift_cnt   <= '0;
              tile_done_r <= 1'b1;
              q_valid_r   <= 1'b0;
              // drain_bank already points at the next tile's bank here.
              if (bank_full[drain_bank]) begin
                state   <= LOAD;
                wr_en_r <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          wr_en_r   <= 1'b0;
          q_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tile_stage_loader.sv
// Bench for tile_stage_loader: directed steps plus a randomized phase,
// with a word-queue scoreboard and a behavioural transpose-FIFO model.
module tb_tile_stage_loader;
  localparam int DEPTH = 8;
  localparam int BITS  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tile_stage_loader_if #(.DEPTH(DEPTH), .BITS(BITS)) bus ();

  tile_stage_loader #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepted words in arrival order; words loaded into the
  // FIFO leave the queue as they are shifted out.
  logic [63:0]     exp_q [$];
  logic [BITS-1:0] fifo_img [DEPTH];
  int              head = 0;
  bit              active = 0;
  bit              done_pend = 0;
  int              in_banks;
  logic [63:0]     want;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      active = 0; done_pend = 0; head = 0;
    end else begin
      in_banks = exp_q.size() - (active ? DEPTH - head : 0);
      check("mon_in_ready", bus.in_ready, 64'(in_banks < 2 * DEPTH));
      check("mon_busy", bus.busy, 64'((in_banks >= DEPTH) || active));
      check("mon_q_valid", bus.q_valid, 64'(active));
      check("mon_shift_en", bus.shift_en, 64'(active && bus.drain_ready));
      check("mon_tile_done", bus.tile_done, 64'(done_pend));
      check("mon_fifo_d", bus.fifo_d, 64'd0);
      done_pend = 0;
      if (flush) begin
        exp_q.delete();
        active = 0; head = 0;
      end else begin
        if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
        if (active && bus.shift_en) begin
          if (exp_q.size() == 0) begin
            check("mon_sb_underflow", 64'd1, 64'd0);
          end else begin
            want = exp_q.pop_front();
            check("mon_q_word", fifo_img[head], want);
          end
          head++;
          if (head == DEPTH) begin active = 0; done_pend = 1; end
        end
        if (bus.wr_en) begin
          check("mon_wr_while_active", 64'(active), 64'd0);
          for (int k = 0; k < DEPTH; k++) fifo_img[k] = bus.p_load[k];
          head = 0; active = 1;
        end
      end
    end
  end

  initial begin
    int acc, idx, wrs, shs, dones, n, to;
    bit seen;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.drain_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    check("rst_in_ready", bus.in_ready, 64'd1);
    check("rst_wr_en", bus.wr_en, 64'd0);
    check("rst_busy", bus.busy, 64'd0);
    for (int k = 0; k < DEPTH; k++) check("rst_p_load", bus.p_load[k], 64'd0);
    rst_n = 1'b1;

    // 1: back-to-back tile with drain_ready high, latency check
    bus.drain_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'(k);
      cycle();
    end
    bus.in_valid = 1'b0;
    #1 check("t1_wr_en_c8", bus.wr_en, 64'd0);
    cycle(); #1;
    check("t1_wr_en_c9", bus.wr_en, 64'd1);
    for (int k = 0; k < DEPTH; k++) check("t1_p_load", bus.p_load[k], 64'(k));
    for (int c = 10; c <= 17; c++) begin
      cycle(); #1;
      check("t1_shift_en", bus.shift_en, 64'd1);
    end
    cycle(); #1;
    check("t1_tile_done_c18", bus.tile_done, 64'd1);
    check("t1_shift_en_c18", bus.shift_en, 64'd0);
    cycle(); #1;
    check("t1_tile_done_c19", bus.tile_done, 64'd0);
    check("t1_busy_c19", bus.busy, 64'd0);

    // 2: drain held low, 30 words offered
    bus.drain_ready = 1'b0;
    acc = 0; idx = 0; wrs = 0; shs = 0;
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'(idx);
      #1;
      if (bus.in_ready) begin acc++; idx++; end
      wrs += int'(bus.wr_en); shs += int'(bus.shift_en);
      cycle();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1; wrs += int'(bus.wr_en); shs += int'(bus.shift_en);
      cycle();
    end
    check("t2_accepted", 64'(acc), 64'd24);
    check("t2_wr_count", 64'(wrs), 64'd1);
    check("t2_shift_count", 64'(shs), 64'd0);
    check("t2_in_ready_low", bus.in_ready, 64'd0);
    bus.drain_ready = 1'b1;
    dones = 0; to = 0;
    #1;
    while ((bus.busy || to < 2) && to < 200) begin
      dones += int'(bus.tile_done);
      cycle(); #1; to++;
    end
    dones += int'(bus.tile_done);
    check("t2_timeout", 64'(to >= 200), 64'd0);
    check("t2_dones", 64'(dones), 64'd3);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3: alternating drain_ready during SHIFT
    bus.drain_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h30 + 64'(k);
      cycle();
    end
    bus.in_valid = 1'b0;
    to = 0; #1;
    while (!bus.q_valid && to < 20) begin cycle(); #1; to++; end
    check("t3_q_valid_timeout", 64'(to >= 20), 64'd0);
    n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      bus.drain_ready = (i % 2 == 0);
      #1;
      if (bus.tile_done) begin
        seen = 1;
        check("t3_shifts_at_done", 64'(n), 64'd8);
      end
      if (bus.shift_en) n++;
      cycle();
    end
    check("t3_done_seen", 64'(seen), 64'd1);
    check("t3_shift_total", 64'(n), 64'd8);

    // 4: flush mid-SHIFT with a partial fill bank
    bus.drain_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h40 + 64'(k);
      cycle();
    end
    bus.in_valid = 1'b0;
    to = 0; #1;
    while (!bus.q_valid && to < 20) begin cycle(); #1; to++; end
    check("t4_q_valid_timeout", 64'(to >= 20), 64'd0);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h50 + 64'(k);
      cycle();
    end
    bus.in_valid = 1'b0;
    shs = 0; to = 0;
    while (shs < 3 && to < 20) begin
      bus.drain_ready = 1'b1;
      #1; if (bus.shift_en) shs++;
      cycle(); to++;
    end
    check("t4_three_shifts", 64'(shs), 64'd3);
    bus.drain_ready = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    check("t4_in_ready", bus.in_ready, 64'd1);
    check("t4_busy", bus.busy, 64'd0);
    check("t4_q_valid", bus.q_valid, 64'd0);
    wrs = 0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h60 + 64'(k);
      #1; wrs += int'(bus.wr_en);
      cycle();
    end
    bus.in_valid = 1'b0;
    #1; wrs += int'(bus.wr_en);
    check("t4_no_early_wr", 64'(wrs), 64'd0);
    cycle(); #1;
    check("t4_wr_en", bus.wr_en, 64'd1);
    for (int k = 0; k < DEPTH; k++) check("t4_p_load", bus.p_load[k], 64'h60 + 64'(k));
    bus.drain_ready = 1'b1;
    to = 0;
    while (bus.busy && to < 50) begin cycle(); #1; to++; end
    check("t4_drain_timeout", 64'(to >= 50), 64'd0);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // 5: async reset mid-SHIFT
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h70 + 64'(k);
      cycle();
    end
    bus.in_valid = 1'b0;
    to = 0; #1;
    while (!bus.q_valid && to < 20) begin cycle(); #1; to++; end
    cycle(); cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t5_shift_en", bus.shift_en, 64'd0);
    check("t5_q_valid", bus.q_valid, 64'd0);
    check("t5_wr_en", bus.wr_en, 64'd0);
    check("t5_busy", bus.busy, 64'd0);
    check("t5_in_ready", bus.in_ready, 64'd1);
    check("t5_tile_done", bus.tile_done, 64'd0);
    for (int k = 0; k < DEPTH; k++) check("t5_p_load", bus.p_load[k], 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    cycle();
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'h80 + 64'(k);
      cycle();
    end
    bus.in_valid = 1'b0;
    to = 0; dones = 0; #1;
    while ((bus.busy || to < 2) && to < 50) begin
      dones += int'(bus.tile_done);
      cycle(); #1; to++;
    end
    dones += int'(bus.tile_done);
    check("t5_dones", 64'(dones), 64'd1);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // 6: randomized traffic with occasional flush
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_data     = {$urandom, $urandom};
      bus.drain_ready = $urandom_range(0, 1) != 0;
      flush           = ($urandom_range(0, 299) == 0);
      cycle();
    end
    flush = 1'b0; bus.in_valid = 1'b0; bus.drain_ready = 1'b1;
    to = 0; #1;
    while (bus.busy && to < 200) begin cycle(); #1; to++; end
    check("t6_drain_timeout", 64'(to >= 200), 64'd0);
    check("t6_residual_partial", 64'(exp_q.size() < DEPTH), 64'd1);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
